key_matrix_scan: RTL and testbench

Scans a 4x4 active-low key matrix and produces a debounced 16-bit key vector. The vector feeds the piano tone/PWM beeper's `key_in` port directly. The block drives one column low at a time and samples the four rows through a synchronizer. It publishes a new vector only after a configurable number of identical full scans.

---
 rtl/key_matrix_scan.sv | 120 ++++++++++++
 tb/tb_key_matrix_scan.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scan.sv
// 4x4 active-low key matrix scanner with scan-level debounce.
// Optional KEY_ONEHOT_EN reduces the published vector to its lowest key.
module key_matrix_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int CNT_W          = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] key_out,
  output logic        key_change
);

  localparam int ST_W = (DEBOUNCE_SCANS < 2) ? 1
                      : $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_ONE  = CNT_W'(1);
  localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(DEBOUNCE_SCANS);
  localparam logic [ST_W-1:0]  ST_ONE   = ST_W'(1);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       row_s_q, row_s_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_out_q, col_out_d;
  logic [15:0]      raw_q, raw_d;
  logic [15:0]      prev_q, prev_d;
  logic [ST_W-1:0]  stable_q, stable_d;
  logic [15:0]      key_q, key_d;
  logic             chg_q, chg_d;

  logic             sample;
  logic             scan_done;
  logic [15:0]      snap;
  logic [15:0]      pub;

  always_comb begin
    sync1_d = row_in;
    row_s_d = sync1_q;

    sample    = (div_q == DIV_LAST);
    scan_done = sample && (col_q == 2'd3);

    div_d     = sample ? '0 : div_q + DIV_ONE;
    col_d     = sample ? col_q + 2'd1 : col_q;
    col_out_d = ~(4'b0001 << col_d);

    // Late sample point: rows have had the whole window to settle.
    raw_d = raw_q;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (col_q == 2'(c)) begin
            raw_d[4*r + c] = ~row_s_q[r];
          end
        end
      end
    end

    snap = raw_d;
`ifdef KEY_ONEHOT_EN
    pub = snap & (~snap + 16'd1);
`else
    pub = snap;
`endif

    prev_d   = prev_q;
    stable_d = stable_q;
    key_d    = key_q;
    chg_d    = 1'b0;

    if (scan_done) begin
      prev_d = snap;
      if (snap != prev_q) begin
        stable_d = ST_ONE;
      end else if (stable_q != ST_MAX) begin
        stable_d = stable_q + ST_ONE;
      end
      // Debounce counts the full snapshot; only publishing is reduced.
      if ((stable_d == ST_MAX) && (pub != key_q)) begin
        key_d = pub;
        chg_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q   <= 4'hF;
      row_s_q   <= 4'hF;
      div_q     <= '0;
      col_q     <= 2'd0;
      col_out_q <= 4'b1110;
      raw_q     <= '0;
      prev_q    <= '0;
      stable_q  <= '0;
      key_q     <= '0;
      chg_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      row_s_q   <= row_s_d;
      div_q     <= div_d;
      col_q     <= col_d;
      col_out_q <= col_out_d;
      raw_q     <= raw_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      key_q     <= key_d;
      chg_q     <= chg_d;
    end
  end

  assign col_out    = col_out_q;
  assign key_out    = key_q;
  assign key_change = chg_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: physical matrix model plus scan-level
// debounce reference model.
module tb_key_matrix_scan;

  localparam int SD    = 4;
  localparam int DB    = 3;
  localparam int SCAN  = 4 * SD;
  localparam int BOUND = (DB + 1) * SCAN + 3;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_out;
  logic        key_change;

  logic [15:0] pressed = 16'h0000;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;

  logic [15:0] m_prev;
  logic [15:0] m_key;
  int          m_stable;
  logic        m_chg;

  key_matrix_scan #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DB),
    .CNT_W          (8)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_out    (key_out),
    .key_change (key_change)
  );

  always #5 clk_in = ~clk_in;

  // Closed key shorts its row to its column when that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col_out[c] && pressed[4*r + c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clk_in) begin
    if (key_change === 1'b1) pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [15:0] reduce(input logic [15:0] v);
`ifdef KEY_ONEHOT_EN
    for (int i = 0; i < 16; i++) begin
      if (v[i]) return 16'(1) << i;
    end
    return 16'h0000;
`else
    return v;
`endif
  endfunction

  task automatic do_reset();
    rst_in   = 1'b1;
    pressed  = 16'h0000;
    m_prev   = 16'h0000;
    m_key    = 16'h0000;
    m_stable = 0;
    m_chg    = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Hold v for one whole scan, then update the scan-level model.
  task automatic run_scan(input logic [15:0] v);
    pressed = v;
    repeat (SCAN) @(posedge clk_in);
    #1;
    m_chg = 1'b0;
    if (v != m_prev) m_stable = 1;
    else if (m_stable < DB) m_stable++;
    m_prev = v;
    if (m_stable == DB && reduce(v) != m_key) begin
      m_key = reduce(v);
      m_chg = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst_in  = 1'b1;
    pressed = 16'h0000;
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if (col_out !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_col got=%b exp=1110", col_out);
    end
    n_cmp++;
    if (key_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_key got=%h exp=0000", key_out);
    end
    n_cmp++;
    if (key_change !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_chg got=%b exp=0", key_change);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < SCAN; i++) begin
      @(posedge clk_in);
      #1;
      e = ~(4'b0001 << (((i + 1) / SD) % 4));
      n_cmp++;
      if (col_out !== e) begin
        n_fail++;
        $display("FAIL col_step[%0d] got=%b exp=%b", i, col_out, e);
      end
    end
  endtask

  task automatic test_single_key();
    int base;
    bit found;
    do_reset();
    base    = pulses;
    pressed = 16'h0020;
    found   = 0;
    for (int i = 0; i < BOUND && !found; i++) begin
      @(negedge clk_in);
      if (key_out === 16'h0020) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL single_press got=%h exp=0020", key_out);
    end
    repeat (4) @(negedge clk_in);
    n_cmp++;
    if (pulses - base !== 1) begin
      n_fail++;
      $display("FAIL single_press_pulses got=%0d exp=1", pulses - base);
    end
    pressed = 16'h0000;
    found   = 0;
    for (int i = 0; i < BOUND && !found; i++) begin
      @(negedge clk_in);
      if (key_out === 16'h0000) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL single_release got=%h exp=0000", key_out);
    end
    repeat (20) @(negedge clk_in);
    n_cmp++;
    if (pulses - base !== 2) begin
      n_fail++;
      $display("FAIL single_release_pulses got=%0d exp=2", pulses - base);
    end
  endtask

  task automatic test_bounce();
    int base;
    bit found;
    do_reset();
    base = pulses;
    for (int i = 0; i < 60; i++) begin
      pressed = ((i / 10) % 2 == 0) ? 16'h0020 : 16'h0000;
      @(negedge clk_in);
      n_cmp++;
      if (key_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL bounce_quiet[%0d] got=%h exp=0000", i, key_out);
      end
    end
    pressed = 16'h0020;
    found   = 0;
    for (int i = 0; i < BOUND && !found; i++) begin
      @(negedge clk_in);
      if (key_out === 16'h0020) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL bounce_settle got=%h exp=0020", key_out);
    end
    repeat (3 * SCAN) @(negedge clk_in);
    n_cmp++;
    if (pulses - base !== 1) begin
      n_fail++;
      $display("FAIL bounce_pulses got=%0d exp=1", pulses - base);
    end
  endtask

  task automatic test_two_keys();
    int base;
    bit found;
    logic [15:0] exp1;
    exp1 = reduce(16'h0420);
    do_reset();
    base    = pulses;
    pressed = 16'h0420;
    found   = 0;
    for (int i = 0; i < BOUND && !found; i++) begin
      @(negedge clk_in);
      if (key_out === exp1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL two_keys got=%h exp=%h", key_out, exp1);
    end
    repeat (2 * SCAN) @(negedge clk_in);
    n_cmp++;
    if (key_out !== exp1 || pulses - base !== 1) begin
      n_fail++;
      $display("FAIL two_keys_hold got=%h/%0d exp=%h/1",
               key_out, pulses - base, exp1);
    end
    pressed = 16'h0400;
    found   = 0;
    for (int i = 0; i < BOUND && !found; i++) begin
      @(negedge clk_in);
      if (key_out === 16'h0400) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL two_keys_release got=%h exp=0400", key_out);
    end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    repeat (DB) run_scan(16'h0020);
    n_cmp++;
    if (key_out !== 16'h0020) begin
      n_fail++;
      $display("FAIL pre_reset_key got=%h exp=0020", key_out);
    end
    repeat (5) @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    n_cmp++;
    if (key_out !== 16'h0000 || col_out !== 4'b1110) begin
      n_fail++;
      $display("FAIL async_reset got=%h/%b exp=0000/1110",
               key_out, col_out);
    end
    do_reset();
    run_scan(16'h0020);
    run_scan(16'h0020);
    repeat (5) @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    n_cmp++;
    if (key_out !== 16'h0000 || col_out !== 4'b1110) begin
      n_fail++;
      $display("FAIL mid_debounce_reset got=%h/%b exp=0000/1110",
               key_out, col_out);
    end
    do_reset();
    for (int s = 0; s < DB; s++) begin
      run_scan(16'h0020);
      n_cmp++;
      if (key_out !== m_key || key_change !== m_chg) begin
        n_fail++;
        $display("FAIL redebounce[%0d] got=%h/%b exp=%h/%b",
                 s, key_out, key_change, m_key, m_chg);
      end
    end
    n_cmp++;
    if (key_out !== 16'h0020) begin
      n_fail++;
      $display("FAIL redebounce_final got=%h exp=0020", key_out);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    do_reset();
    v = 16'h0000;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = 16'h0000;
        if ($urandom_range(0, 4) != 0)
          v = v | (16'(1) << $urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0)
          v = v | (16'(1) << $urandom_range(0, 15));
      end
      run_scan(v);
      n_cmp++;
      if (key_out !== m_key) begin
        n_fail++;
        $display("FAIL rand_key[%0d] got=%h exp=%h", s, key_out, m_key);
      end
      n_cmp++;
      if (key_change !== m_chg) begin
        n_fail++;
        $display("FAIL rand_chg[%0d] got=%b exp=%b",
                 s, key_change, m_chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_two_keys();
    test_reset_mid_debounce();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
